// File: rtl/carrier_pkg.sv
// Shared definitions for the PWM carrier generator: mode encoding and
// the start-value rule used whenever a new period begins.
package carrier_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP   = 2'd0;
  localparam mode_t MODE_DOWN = 2'd1;
  localparam mode_t MODE_TRI  = 2'd2;
  localparam mode_t MODE_RSVD = 2'd3;

  // Widest carrier the start-value helper handles.
  localparam int MAX_WIDTH = 32;

  // The reserved encoding runs exactly like an up-sawtooth.
  function automatic mode_t resolve_mode(input mode_t mode);
    return (mode == MODE_RSVD) ? MODE_UP : mode;
  endfunction

  // First counter value of a period: P-1 for a down-sawtooth, else 0.
  // Degenerate periods (P<2) always start (and stay) at 0.
  function automatic logic [MAX_WIDTH-1:0] start_value(
    input mode_t                 mode,
    input logic [MAX_WIDTH-1:0]  period
  );
    if (resolve_mode(mode) == MODE_DOWN && period >= 2)
      return period - 1;
    return '0;
  endfunction

endpackage

// File: rtl/carrier_pwm_cmp.sv
// Registered PWM comparator with a shadowed duty value. The duty is
// captured on cfg_load and becomes active only when the carrier applies a
// new configuration, so duty changes never glitch mid-period.
module carrier_pwm_cmp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic             apply,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] count,
  output logic             pwm_out
);

  logic [WIDTH-1:0] shd_duty;
  logic [WIDTH-1:0] act_duty;

  // Duty shadow/active update and registered compare against the carrier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shd_duty <= '0;
      act_duty <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (cfg_load)
        shd_duty <= duty;
      if (apply)
        act_duty <= cfg_load ? duty : shd_duty;
      pwm_out <= (act_duty > count);
    end
  end

endmodule

// File: rtl/carrier_generator.sv
// Programmable PWM carrier: up-sawtooth, down-sawtooth or triangle with a
// run-time period. Period/mode go through a shadow register and are taken
// over only at a period boundary (or immediately while disabled).
// Optional comparator output: define CARRIER_PWM_CMP_EN to add the duty
// input and pwm_out output. WIDTH must be between 2 and 32.
module carrier_generator
  import carrier_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int RESET_PERIOD = 2**WIDTH - 1,
  parameter int RESET_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [1:0]       cfg_mode,
`ifdef CARRIER_PWM_CMP_EN
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out,
`endif
  output logic [WIDTH-1:0] carrier_out,
  output logic             period_start,
  output logic             cfg_pending
);

  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(RESET_PERIOD);
  localparam mode_t            RST_MODE   = mode_t'(RESET_MODE);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO        = WIDTH'(2);

  logic [WIDTH-1:0] act_period;
  logic [WIDTH-1:0] shd_period;
  mode_t            act_mode;
  mode_t            shd_mode;
  logic             dir_down;

  mode_t            run_mode;
  logic [WIDTH-1:0] last_value;
  logic             at_boundary;
  logic             apply;
  logic [WIDTH-1:0] new_period;
  mode_t            new_mode;
  logic [WIDTH-1:0] start_count;
  logic [WIDTH-1:0] next_count;
  logic             next_dir_down;

  assign run_mode   = resolve_mode(act_mode);
  assign last_value = act_period - ONE;

  // The shadow captures every cfg_load, including bypassed ones, so when
  // nothing is pending it already equals the active configuration. Taking
  // the shadow at a boundary is therefore correct with or without pending.
  assign new_period  = cfg_load ? cfg_period : shd_period;
  assign new_mode    = cfg_load ? mode_t'(cfg_mode) : shd_mode;
  assign start_count = WIDTH'(start_value(new_mode, MAX_WIDTH'(new_period)));

  // Enabled: restart at the boundary. Disabled: a cfg_load restarts at once.
  assign apply = enable ? at_boundary : cfg_load;

  // Detect the last value of the current period for the active mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and a latch is never inferred.
    at_boundary = 1'b0;
    if (act_period < TWO) begin
      at_boundary = 1'b1;
    end else begin
      case (run_mode)
        MODE_DOWN: at_boundary = (carrier_out == '0);
        MODE_TRI:  at_boundary = (carrier_out == ONE) &&
                                 (dir_down || act_period == TWO);
        default:   at_boundary = (carrier_out == last_value);
      endcase
    end
  end

  // Step the counter within a period; the triangle turns around at P-1.
  always_comb begin
    next_count    = carrier_out + ONE;
    next_dir_down = dir_down;
    case (run_mode)
      MODE_DOWN: next_count = carrier_out - ONE;
      MODE_TRI: begin
        if (dir_down) begin
          next_count = carrier_out - ONE;
        end else if (carrier_out == last_value) begin
          next_count    = carrier_out - ONE;
          next_dir_down = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Carrier counter, configuration shadow/active registers and strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carrier_out  <= '0;
      dir_down     <= 1'b0;
      period_start <= 1'b0;
      cfg_pending  <= 1'b0;
      act_period   <= RST_PERIOD;
      act_mode     <= RST_MODE;
      shd_period   <= RST_PERIOD;
      shd_mode     <= RST_MODE;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (cfg_load) begin
        shd_period <= cfg_period;
        shd_mode   <= mode_t'(cfg_mode);
      end
      if (apply) begin
        act_period   <= new_period;
        act_mode     <= new_mode;
        carrier_out  <= start_count;
        dir_down     <= 1'b0;
        period_start <= 1'b1;
        cfg_pending  <= 1'b0;
      end else begin
        period_start <= 1'b0;
        if (enable) begin
          carrier_out <= next_count;
          dir_down    <= next_dir_down;
        end
        if (cfg_load)
          cfg_pending <= 1'b1;
      end
    end
  end

`ifdef CARRIER_PWM_CMP_EN
  carrier_pwm_cmp #(
    .WIDTH (WIDTH)
  ) u_pwm_cmp (
    .clk      (clk),
    .reset    (reset),
    .cfg_load (cfg_load),
    .apply    (apply),
    .duty     (duty),
    .count    (carrier_out),
    .pwm_out  (pwm_out)
  );
`endif

endmodule

// File: tb/tb_carrier_generator.sv
// Self-checking bench for carrier_generator (WIDTH=8, reset period 5, UP).
// Hand-built vector table for the directed scenarios, then randomized
// traffic against a phase-index reference model.
module tb_carrier_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_period = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] carrier_out;
  logic       period_start;
  logic       cfg_pending;
`ifdef CARRIER_PWM_CMP_EN
  logic [7:0] duty = '0;
  logic       pwm_out;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  carrier_generator #(
    .WIDTH        (8),
    .RESET_PERIOD (5),
    .RESET_MODE   (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_load     (cfg_load),
    .cfg_period   (cfg_period),
    .cfg_mode     (cfg_mode),
`ifdef CARRIER_PWM_CMP_EN
    .duty         (duty),
    .pwm_out      (pwm_out),
`endif
    .carrier_out  (carrier_out),
    .period_start (period_start),
    .cfg_pending  (cfg_pending)
  );

  // ---------------- reference model (position within period) -------------
  int m_idx, m_ap, m_am, m_sp, m_sm;
  bit m_ps, m_pend;

  function automatic int period_len(input int p, input int m);
    if (p < 2) return 1;
    if (m == 2) return 2 * (p - 1);
    return p;
  endfunction

  function automatic int model_value();
    if (m_ap < 2) return 0;
    case (m_am)
      1:       return m_ap - 1 - m_idx;
      2:       return (m_idx < m_ap) ? m_idx : 2 * (m_ap - 1) - m_idx;
      default: return m_idx;
    endcase
  endfunction

  task automatic model_reset();
    m_idx = 0; m_ap = 5; m_am = 0; m_sp = 5; m_sm = 0; m_ps = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input int p, input int m);
    if (!en) begin
      m_ps = 0;
      if (ld) begin
        m_ap = p; m_am = m; m_sp = p; m_sm = m;
        m_idx = 0; m_ps = 1; m_pend = 0;
      end
    end else if (m_idx == period_len(m_ap, m_am) - 1) begin
      if (ld) begin
        m_ap = p; m_am = m; m_sp = p; m_sm = m;
      end else if (m_pend) begin
        m_ap = m_sp; m_am = m_sm;
      end
      m_idx = 0; m_ps = 1; m_pend = 0;
    end else begin
      m_idx++;
      m_ps = 0;
      if (ld) begin
        m_sp = p; m_sm = m; m_pend = 1;
      end
    end
  endtask

  // ---------------- helpers ----------------------------------------------
  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic drive_edge(input bit en, input bit ld, input int p, input int m);
    logic [31:0] pv, mv;
    pv = p;
    mv = m;
    enable     = en;
    cfg_load   = ld;
    cfg_period = pv[7:0];
    cfg_mode   = mv[1:0];
    @(posedge clk);
    model_step(en, ld, p, m);
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic cycle(input bit en, input bit ld, input int p, input int m);
    drive_edge(en, ld, p, m);
    check("carrier", int'(carrier_out), model_value());
    check("period_start", int'(period_start), int'(m_ps));
    check("cfg_pending", int'(cfg_pending), int'(m_pend));
  endtask

  // ---------------- directed vector table --------------------------------
  typedef struct {
    bit en; bit ld; int period; int mode;
    int exp_c; bit exp_ps; bit exp_pd;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit en, input bit ld, input int p, input int m,
                              input int c, input bit ps, input bit pd);
    vec_t v;
    v.en = en; v.ld = ld; v.period = p; v.mode = m;
    v.exp_c = c; v.exp_ps = ps; v.exp_pd = pd;
    vecs.push_back(v);
  endfunction

  function automatic void build_table();
    // UP P=5 from reset; load DOWN P=4 at carrier 2
    add(1,0,0,0, 1,0,0); add(1,0,0,0, 2,0,0); add(1,1,4,1, 3,0,1);
    add(1,0,0,0, 4,0,1); add(1,0,0,0, 3,1,0); add(1,0,0,0, 2,0,0);
    add(1,0,0,0, 1,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 3,1,0);
    add(1,0,0,0, 2,0,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 0,0,0);
    // bypass load of TRI P=4 at the DOWN boundary
    add(1,1,4,2, 0,1,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 2,0,0);
    add(1,0,0,0, 3,0,0); add(1,0,0,0, 2,0,0); add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 0,1,0); add(1,0,0,0, 1,0,0);
    // two loads mid-period: P=7 then P=9, only P=9 survives
    add(1,1,7,0, 2,0,1); add(1,1,9,0, 3,0,1); add(1,0,0,0, 2,0,1);
    add(1,0,0,0, 1,0,1); add(1,0,0,0, 0,1,0);
    for (int i = 1; i <= 7; i++) add(1,0,0,0, i,0,0);
    add(1,1,0,0, 8,0,1);   // queue P=0 while reaching 8 (P=9 wraps after 8)
    add(1,0,0,0, 0,1,0); add(1,0,0,0, 0,1,0);
    add(1,1,1,1, 0,1,0); add(1,0,0,0, 0,1,0);
    // UP P=6, freeze at 3 for three cycles
    add(1,1,6,0, 0,1,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 2,0,0);
    add(1,0,0,0, 3,0,0); add(0,0,0,0, 3,0,0); add(0,0,0,0, 3,0,0);
    add(0,0,0,0, 3,0,0); add(1,0,0,0, 4,0,0); add(1,0,0,0, 5,0,0);
    add(1,0,0,0, 0,1,0);
    // cfg_load while disabled applies on the next edge
    add(0,1,5,1, 4,1,0); add(0,0,0,0, 4,0,0); add(1,0,0,0, 3,0,0);
    add(0,1,3,0, 0,1,0); add(1,0,0,0, 1,0,0);
  endfunction

  // ---------------- main sequence ----------------------------------------
  initial begin
    bit hit;
    model_reset();
    build_table();
    #2;
    check("reset_carrier", int'(carrier_out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_cfg_pending", int'(cfg_pending), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive_edge(vecs[i].en, vecs[i].ld, vecs[i].period, vecs[i].mode);
      check($sformatf("vec%0d_carrier", i), int'(carrier_out), vecs[i].exp_c);
      check($sformatf("vec%0d_period_start", i), int'(period_start), int'(vecs[i].exp_ps));
      check($sformatf("vec%0d_cfg_pending", i), int'(cfg_pending), int'(vecs[i].exp_pd));
    end

    // TRI P=255: run up to 200, leave a pending load, then async reset
    cycle(1, 1, 255, 2);
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      cycle(1, 0, 0, 0);
      if (model_value() == 200) hit = 1;
    end
    check("tri_reach_200", int'(carrier_out), 200);
    cycle(1, 1, 10, 0);
    check("pending_before_reset", int'(cfg_pending), 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_carrier", int'(carrier_out), 0);
    check("async_reset_period_start", int'(period_start), 0);
    check("async_reset_cfg_pending", int'(cfg_pending), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 0, 0, 0);   // continues from 0 to 1, no strobe

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int p, m;
      bit en, ld;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 11) == 0);
      p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 12));
      m  = int'($urandom_range(0, 3));
      cycle(en, ld, p, m);
    end

`ifdef CARRIER_PWM_CMP_EN
    duty = 8'd3;
    cycle(0, 1, 10, 0);
    for (int i = 0; i < 12; i++) begin
      int prev;
      prev = model_value();
      cycle(1, 0, 0, 0);
      check("pwm_out", int'(pwm_out), (prev < 3) ? 1 : 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/carrier_generator.md
Name: carrier_generator

Overview:
- Parametrised successor of the single-mode 8-bit sawtooth counter.
- Produces a WIDTH-bit PWM carrier in three modes: up-sawtooth, down-sawtooth, and triangle.
- Period and mode are programmable at run time through double-buffered (shadow) registers, applied glitch-free only at period boundaries.
- Sits between the control/register interface and the PWM comparators; provides a period-start strobe for synchronising duty updates.

Parameters:
- WIDTH, 8, carrier/period bit width (≥2).
- RESET_PERIOD, 2**WIDTH-1, active period after reset.
- RESET_MODE, 0, active mode after reset (package encoding).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  count enable; low freezes the carrier.
- cfg_load  in  1  one-cycle strobe; captures cfg_period/cfg_mode into shadow.
- cfg_period  in  WIDTH  requested period P.
- cfg_mode  in  2  requested mode.
- carrier_out  out  WIDTH  carrier value; this is the counter register itself.
- period_start  out  1  one-cycle strobe, high in the cycle carrier_out shows a period's first value.
- cfg_pending  out  1  shadow holds a value not yet applied.

Behaviour:
- Reset (reset=0, async):
  - counter=0, active period=RESET_PERIOD, active mode=RESET_MODE, direction=up.
  - period_start=0, cfg_pending=0, shadow=reset values.
  - First enabled cycle after release continues from 0; no period_start strobe.
- Mode encoding:
  - 0 UP: sequence 0,1..P-1, then wrap to 0. Period P cycles.
  - 1 DOWN: sequence P-1..0, then wrap to P-1. Period P cycles.
  - 2 TRI: sequence 0 up to P-1, then down to 1, then 0. Period 2(P-1) cycles. Direction flag flips at the peaks.
  - 3: reserved; behaves as UP.
- Degenerate periods (P<2) in any mode: counter held at 0; every enabled cycle is a boundary and asserts period_start.
- Boundary: the enabled cycle in which the counter sits at the mode's end value (UP: P-1; DOWN: 0; TRI: 1 while counting down).
- At a boundary:
  - Active period/mode are loaded from the shadow if cfg_pending=1.
  - Counter loads the new mode's start value (0, or P_new-1 for DOWN); direction is set to up.
  - period_start is registered high for the next cycle.
  - cfg_pending clears.
- cfg_load:
  - Shadow captures the inputs; cfg_pending=1 from the next cycle.
  - A later cfg_load before the boundary overwrites the shadow (last write wins).
- cfg_load in the same cycle as a boundary: the cfg inputs are applied directly (bypass) and cfg_pending stays 0.
- cfg_load while enable=0: values apply on the next edge (counter restarts at the new start value, period_start pulses); cfg_pending never set.
- enable=0: counter, direction and period_start held/0; the shadow still accepts cfg_load.
- Arithmetic:
  - All counter math is WIDTH-bit unsigned with no overflow.
  - P=2**WIDTH-1 is the maximum period; UP reaches 2**WIDTH-2.
- Latency: carrier_out is a register; a change takes effect at the clock edge after the causing cycle.

Optional Feature:
- Macro: CARRIER_PWM_CMP_EN.
- Defined:
  - Adds input duty (WIDTH) and output pwm_out (1).
  - duty is shadowed and applied only at boundaries, same rules as cfg.
  - pwm_out is registered: 1 when active duty > counter value of the cycle; reset 0.
  - duty=0 gives constant 0; duty≥P gives constant 1.
- Undefined: no duty port, no pwm_out port, no comparator logic.

Decomposition:
- Package carrier_pkg:
  - Mode localparams MODE_UP=2'd0, MODE_DOWN=2'd1, MODE_TRI=2'd2, MODE_RSVD=2'd3.
  - Mode typedef.
  - Function returning start value for (mode, period).
- One sub-module carrier_pwm_cmp: registered comparator with duty shadow; instantiated only under CARRIER_PWM_CMP_EN.

Test Plan:
- WIDTH=8, reset period 5, mode UP, enable=1 → carrier 0,1,2,3,4,0…; period_start high on each returning 0 after the first wrap.
- cfg_load P=4, DOWN at carrier=2 of a P=5 UP cycle → cfg_pending=1; UP finishes 3,4; then DOWN 3,2,1,0,3…; cfg_pending clears with the first 3.
- TRI, P=4 → 0,1,2,3,2,1,0,1…; period 6 cycles; period_start on each 0.
- Two cfg_loads mid-period (P=7 then P=9), then a boundary → only P=9 applied; cfg_load coincident with the boundary → applied immediately, cfg_pending stays 0.
- P=0 and P=1 → carrier stuck at 0, period_start high every enabled cycle; enable low for 3 cycles mid-count at 3 → holds 3, no strobe, resumes at 4.
- Reset asserted mid-TRI at 200 (P=255) → carrier 0 and outputs cleared immediately without a clock edge; with CARRIER_PWM_CMP_EN, P=10, duty=3 → pwm_out high for counter 0,1,2 only.
